data_deser: RTL and testbench
=============================

Name: data_deser

Overview:
- Downstream neighbour of the data synchroniser.
- Consumes its synchronised serial bit stream (dout plus dready_o strobe) and assembles WIDTH-bit words.
- Presents each word through a one-entry valid/ready output register.
- Flags overflow when the consumer stalls, and discards stale partial words after an inactivity timeout.

Parameters:
- WIDTH, 8, bits per assembled word (>=1)
- MSB_FIRST, 1, 1: first received bit lands in data_o[WIDTH-1]; 0: first bit lands in data_o[0]
- TIMEOUT, 16, consecutive strobe-free cycles inside a partial word before it is discarded (>=2)

Ports:
- clk  in  1  single system clock, rising edge
- rstn  in  1  asynchronous active-low reset
- bit_i  in  1  serial data bit (synchroniser dout)
- bit_vld_i  in  1  bit strobe, one bit per high cycle (synchroniser dready_o)
- data_o  out  WIDTH  assembled word
- valid_o  out  1  data_o holds an unconsumed word
- ready_i  in  1  consumer accepts data_o when valid_o & ready_i
- ovf_o  out  1  sticky: a completed word was dropped
- ovf_clr_i  in  1  clears ovf_o
- tmo_o  out  1  one-cycle pulse: partial word discarded by timeout

Behaviour:
- Reset (async assert, sync-safe deassert):
  - data_o=0, valid_o=0, ovf_o=0, tmo_o=0.
  - State goes to IDLE; bit counter, shift register and idle counter are 0.
  - Reset mid-word discards the partial word silently.
- FSM states: IDLE (no bits held) and SHIFT (1..WIDTH-1 bits held).
  - IDLE -> SHIFT on bit_vld_i when WIDTH>1.
  - SHIFT -> IDLE on word completion or timeout.
- Shifting, on each clk edge with bit_vld_i=1:
  - MSB_FIRST=1: shreg <= {shreg[WIDTH-2:0], bit_i}.
  - MSB_FIRST=0: shreg <= {bit_i, shreg[WIDTH-1:1]}.
  - The bit counter increments.
  - bit_vld_i=0 means no change.
- Completion is the edge sampling the WIDTH-th bit:
  - The full word (including that bit) is offered to the holding register.
  - The bit counter returns to 0.
  - valid_o rises the cycle after that edge, so latency is 1 cycle from the last strobe.
- Holding register:
  - Free when valid_o=0, or when valid_o&ready_i in the same cycle as completion. Back-to-back words with ready_i=1 are lossless.
  - If not free: the new word is dropped, data_o is unchanged, and ovf_o sets at that edge.
  - valid_o clears on valid_o&ready_i when no new word is loading.
  - data_o stays stable while valid_o=1 and ready_i=0.
- ovf_o: sticky until an ovf_clr_i edge. Simultaneous set and clear: set wins.
- Timeout:
  - The idle counter increments each SHIFT cycle with bit_vld_i=0 and resets to 0 on any strobe.
  - On the edge where the counter equals TIMEOUT-1 and bit_vld_i=0: shift register and bit counter clear, state goes to IDLE, and tmo_o=1 for exactly the next cycle.
  - A strobe in that same cycle wins and no timeout fires.
  - There is no timeout in IDLE.
- WIDTH=1: every strobe completes a word, the FSM stays in IDLE, and timeout never fires.
- The input has no back-pressure. A strobe is accepted every cycle without exception.

Decomposition:
- Shared package/include holds:
  - FSM state encoding (ST_IDLE, ST_SHIFT).
  - Width helpers: CNT_W = clog2(WIDTH+1), TMO_W = clog2(TIMEOUT).
- One natural sub-module: deser_hold. It is the one-entry valid/ready holding register with a drop/overflow indication, reusable by other stream stages.
- Shifting, counting and timeout logic live in data_deser.

Test Plan:
- Reset, then 8 strobes in consecutive cycles carrying 1,0,1,0,1,0,1,1 with MSB_FIRST=1, ready_i=1 -> data_o=8'hAB, valid_o high exactly 1 cycle, starting the cycle after the 8th strobe.
- Same stream with MSB_FIRST=0 -> data_o=8'hD5.
- ready_i=0; send 8'hAA then 8'h55 -> data_o holds 8'hAA and ovf_o=1 after the 16th strobe. Pulse ovf_clr_i -> ovf_o=0. Assert ready_i -> valid_o drops.
- Send 3 bits, then 16 strobe-free cycles -> tmo_o pulses once. Next 8 bits for 8'h07 -> data_o=8'h07, with no leftover bits.
- Send 3 bits, idle 15 cycles, strobe on cycle 16 -> no tmo_o. Word continues with 4 bits held.
- Assert rstn=0 after 5 bits, release, then send 8'h08 -> data_o=8'h08; all outputs were 0 during reset.

Source files
------------

// File: rtl/data_deser_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | data_deser_pkg                                                       |
// | Shared state encoding and width helpers for the serial deserialiser. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package data_deser_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Bit counter must hold 0..WIDTH.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  // Idle counter only ever reaches TIMEOUT-1.
  function automatic int tmo_width(input int timeout);
    return $clog2(timeout);
  endfunction

endpackage
`default_nettype wire

// File: rtl/data_deser_hold.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | deser_hold                                                           |
// | One-entry valid/ready holding register with drop indication.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module deser_hold
  import data_deser_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_drop
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic             w_free;

  // A word being consumed this cycle frees the slot for a same-cycle load.
  assign w_free = ~r_valid | i_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      if (i_load && w_free) begin
        r_data  <= i_data;
        r_valid <= 1'b1;
      end else if (r_valid && i_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;
  assign o_drop  = i_load & ~w_free;

endmodule
`default_nettype wire

// File: rtl/data_deser.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | data_deser                                                           |
// | Serial-to-parallel word assembler with hold register and timeout.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module data_deser
  import data_deser_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int TIMEOUT   = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             bit_i,
  input  logic             bit_vld_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             ovf_o,
  input  logic             ovf_clr_i,
  output logic             tmo_o
);

  localparam int c_CNT_W = cnt_width(WIDTH);
  localparam int c_TMO_W = tmo_width(TIMEOUT);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_CNT_W-1:0] r_cnt;
  logic [c_TMO_W-1:0] r_idle;
  logic [WIDTH-1:0]   r_shreg;
  logic [WIDTH-1:0]   w_shreg_nxt;
  logic               w_complete;
  logic               w_tmo_fire;
  logic               w_drop;
  logic               r_ovf;
  logic               r_tmo;

  generate
    if (WIDTH == 1) begin : g_single
      assign w_shreg_nxt = bit_i;
    end else if (MSB_FIRST) begin : g_msb_first
      assign w_shreg_nxt = {r_shreg[WIDTH-2:0], bit_i};
    end else begin : g_lsb_first
      assign w_shreg_nxt = {bit_i, r_shreg[WIDTH-1:1]};
    end
  endgenerate

  assign w_complete = bit_vld_i && (r_cnt == c_CNT_W'(WIDTH - 1));
  // A strobe in the expiry cycle keeps the partial word alive.
  assign w_tmo_fire = (r_state == ST_SHIFT) && !bit_vld_i
                      && (r_idle == c_TMO_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      // With WIDTH=1 every strobe completes, so IDLE is never left.
      ST_IDLE:  if (bit_vld_i && !w_complete) w_state_nxt = ST_SHIFT;
      ST_SHIFT: if (w_complete || w_tmo_fire) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_shreg <= '0;
      r_cnt   <= '0;
      r_idle  <= '0;
    end else begin
      if (bit_vld_i) begin
        r_idle <= '0;
        if (w_complete) begin
          r_shreg <= '0;
          r_cnt   <= '0;
        end else begin
          r_shreg <= w_shreg_nxt;
          r_cnt   <= r_cnt + c_CNT_W'(1);
        end
      end else if (w_tmo_fire) begin
        r_shreg <= '0;
        r_cnt   <= '0;
        r_idle  <= '0;
      end else if (r_state == ST_SHIFT) begin
        r_idle <= r_idle + c_TMO_W'(1);
      end
    end
  end

  deser_hold #(
    .WIDTH (WIDTH)
  ) u_hold (
    .clk     (clk),
    .rstn    (rstn),
    .i_load  (w_complete),
    .i_data  (w_shreg_nxt),
    .i_ready (ready_i),
    .o_data  (data_o),
    .o_valid (valid_o),
    .o_drop  (w_drop)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ovf <= 1'b0;
      r_tmo <= 1'b0;
    end else begin
      r_tmo <= w_tmo_fire;
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (ovf_clr_i) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign ovf_o = r_ovf;
  assign tmo_o = r_tmo;

endmodule
`default_nettype wire

// File: tb/tb_data_deser.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_data_deser                                                        |
// | Directed bench for data_deser (MSB-first and LSB-first instances).  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_data_deser;

  localparam int W   = 8;
  localparam int TMO = 16;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         bit_i = 1'b0;
  logic         bit_vld_i = 1'b0;
  logic         ready_i = 1'b0;
  logic         ovf_clr_i = 1'b0;
  logic [W-1:0] data_m, data_l;
  logic         valid_m, valid_l, ovf_m, ovf_l, tmo_m, tmo_l;

  int checks = 0;
  int errors = 0;

  // Behavioural model: partial word as a queue of received bits.
  bit           mq[$];
  int           m_idle;
  logic         m_valid, m_ovf, m_tmo;
  logic [W-1:0] m_data_m, m_data_l;

  always #5 clk = ~clk;

  data_deser #(.WIDTH(W), .MSB_FIRST(1'b1), .TIMEOUT(TMO)) dut (
    .clk(clk), .rstn(rstn), .bit_i(bit_i), .bit_vld_i(bit_vld_i),
    .data_o(data_m), .valid_o(valid_m), .ready_i(ready_i),
    .ovf_o(ovf_m), .ovf_clr_i(ovf_clr_i), .tmo_o(tmo_m)
  );

  data_deser #(.WIDTH(W), .MSB_FIRST(1'b0), .TIMEOUT(TMO)) dut_lsb (
    .clk(clk), .rstn(rstn), .bit_i(bit_i), .bit_vld_i(bit_vld_i),
    .data_o(data_l), .valid_o(valid_l), .ready_i(ready_i),
    .ovf_o(ovf_l), .ovf_clr_i(ovf_clr_i), .tmo_o(tmo_l)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_idle   = 0;
    m_valid  = 1'b0;
    m_ovf    = 1'b0;
    m_tmo    = 1'b0;
    m_data_m = '0;
    m_data_l = '0;
  endtask

  task automatic model_update();
    logic         load, tmo_n, ovf_set;
    logic [W-1:0] wm, wl, b;
    load = 1'b0; tmo_n = 1'b0; ovf_set = 1'b0; wm = '0; wl = '0;
    if (bit_vld_i) begin
      mq.push_back(bit_i);
      m_idle = 0;
      if (mq.size() == W) begin
        for (int i = 0; i < W; i++) begin
          b  = W'(mq[i]);
          wm = wm | (b << (W - 1 - i));
          wl = wl | (b << i);
        end
        load = 1'b1;
        mq.delete();
      end
    end else if (mq.size() != 0) begin
      m_idle++;
      if (m_idle == TMO) begin
        mq.delete();
        m_idle = 0;
        tmo_n  = 1'b1;
      end
    end
    if (load) begin
      if (!m_valid || ready_i) begin
        m_valid  = 1'b1;
        m_data_m = wm;
        m_data_l = wl;
      end else begin
        ovf_set = 1'b1;
      end
    end else if (m_valid && ready_i) begin
      m_valid = 1'b0;
    end
    if (ovf_set) m_ovf = 1'b1;
    else if (ovf_clr_i) m_ovf = 1'b0;
    m_tmo = tmo_n;
  endtask

  // One clock: apply inputs, let the edge happen, advance the model.
  task automatic step(input logic vld, input logic b);
    bit_vld_i = vld;
    bit_i     = b;
    @(posedge clk);
    if (rstn) model_update();
    #1;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) step(1'b1, v[i]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  always @(negedge clk) begin
    chk("valid_msb", valid_m, m_valid);
    chk("valid_lsb", valid_l, m_valid);
    chk("data_msb",  data_m,  m_data_m);
    chk("data_lsb",  data_l,  m_data_l);
    chk("ovf_msb",   ovf_m,   m_ovf);
    chk("ovf_lsb",   ovf_l,   m_ovf);
    chk("tmo_msb",   tmo_m,   m_tmo);
    chk("tmo_lsb",   tmo_l,   m_tmo);
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_data", data_m, 32'h0);
    chk("reset_valid", valid_m, 32'h0);
    rstn = 1'b1;
    ready_i = 1'b1;
    step(1'b0, 1'b0);

    // 1,0,1,0,1,0,1,1
    send_byte(8'hAB);
    chk("t1_data_msb", data_m, 32'hAB);
    chk("t1_data_lsb", data_l, 32'hD5);
    chk("t1_valid_rise", valid_m, 32'h1);
    step(1'b0, 1'b0);
    chk("t1_valid_one_cycle", valid_m, 32'h0);

    ready_i = 1'b0;
    send_byte(8'hAA);
    send_byte(8'h55);
    chk("t3_hold_data", data_m, 32'hAA);
    chk("t3_ovf_set", ovf_m, 32'h1);
    ovf_clr_i = 1'b1;
    step(1'b0, 1'b0);
    ovf_clr_i = 1'b0;
    chk("t3_ovf_clr", ovf_m, 32'h0);
    ready_i = 1'b1;
    step(1'b0, 1'b0);
    chk("t3_valid_drop", valid_m, 32'h0);

    step(1'b1, 1'b1); step(1'b1, 1'b1); step(1'b1, 1'b1);
    idle(15);
    chk("t4_no_tmo_yet", tmo_m, 32'h0);
    idle(1);
    chk("t4_tmo_pulse", tmo_m, 32'h1);
    idle(1);
    chk("t4_tmo_once", tmo_m, 32'h0);
    send_byte(8'h07);
    chk("t4_data_clean", data_m, 32'h07);
    chk("t4_data_clean_lsb", data_l, 32'hE0);

    step(1'b1, 1'b1); step(1'b1, 1'b0); step(1'b1, 1'b1);
    idle(15);
    step(1'b1, 1'b1);
    chk("t5_no_tmo", tmo_m, 32'h0);
    step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b1, 1'b1); step(1'b1, 1'b1);
    chk("t5_data_msb", data_m, 32'hB3);
    chk("t5_data_lsb", data_l, 32'hCD);
    chk("t5_valid", valid_m, 32'h1);

    idle(2);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1);
    rstn = 1'b0;
    model_reset();
    #1;
    chk("t6_rst_data", data_m, 32'h0);
    chk("t6_rst_valid", valid_m, 32'h0);
    chk("t6_rst_ovf", ovf_m, 32'h0);
    chk("t6_rst_tmo", tmo_m, 32'h0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    rstn = 1'b1;
    step(1'b0, 1'b0);
    send_byte(8'h08);
    chk("t6_data_msb", data_m, 32'h08);
    chk("t6_data_lsb", data_l, 32'h10);
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
